rm_frame_sched: RTL
===================

RM_FRAME_SCHED -- requirements
Module: rm_frame_sched

Interface
REQ-001 SHALL have parameter CMP_BLKS, default 900, meaning compressed block pairs per frame (range 1..2047).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1048576, meaning the watchdog limit in clock cycles.
REQ-003 SHALL have port clock  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cmp_req  in  1  compress frame request, level, held until frame_done.
REQ-006 SHALL have port dec_req  in  1  decompress frame request, level, held until frame_done.
REQ-007 SHALL have port yc_sof  in  1  start-of-frame pulse from the display processor.
REQ-008 SHALL have port cmp_blk_done  in  1  one-cycle pulse per compressed block pair read out of the rate-match buffer.
REQ-009 SHALL have port last_dec_blk  in  1  level from the rate-match buffer, high after the final IDCT block.
REQ-010 SHALL have port err_clr  in  1  pulse that clears err_timeout.
REQ-011 SHALL have port compress_on  out  1  selects compress mode in the rate-match buffer.
REQ-012 SHALL have port compress_start  out  1  one-cycle pulse.
REQ-013 SHALL have port decompress_start  out  1  one-cycle pulse.
REQ-014 SHALL have ports cmp_busy and dec_busy  out  1 each  high while the owning frame is in progress.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at the end of a frame.
REQ-016 SHALL have port blk_cnt  out  11  compressed block pairs counted in the current frame.
REQ-017 SHALL have port err_timeout  out  1  sticky watchdog error.

Function
REQ-018 SHALL implement the states IDLE, CMP_ARM, CMP_RUN, DEC_START, DEC_RUN and DONE; all outputs SHALL be registered.
REQ-019 In IDLE, when only one request is high, the FSM SHALL move on the next edge to CMP_ARM (cmp_req) or DEC_START (dec_req).
REQ-020 When both requests are high in IDLE, the FSM SHALL grant the type not served last (round-robin); last_served SHALL be DEC after reset, so compress wins first.
REQ-021 compress_on and cmp_busy SHALL be high in CMP_ARM and CMP_RUN and low in every other state.
REQ-022 In CMP_ARM, if cmp_req drops before yc_sof, the FSM SHALL return to IDLE with no compress_start and no frame_done.
REQ-023 In CMP_ARM, when yc_sof=1 the FSM SHALL enter CMP_RUN, with compress_start=1 for exactly that first CMP_RUN cycle and blk_cnt cleared to 0.
REQ-024 In CMP_RUN, each cmp_blk_done SHALL increment blk_cnt; the pulse with blk_cnt==CMP_BLKS-1 SHALL move the FSM to DONE.
REQ-025 yc_sof in CMP_RUN, and cmp_blk_done outside CMP_RUN, SHALL be ignored.
REQ-026 DEC_START SHALL last exactly one cycle, with decompress_start=1, dec_busy=1 and compress_on=0, and SHALL then enter DEC_RUN.
REQ-027 In DEC_RUN, the FSM SHALL go to DONE on a 0->1 edge of last_dec_blk.
REQ-028 The last_dec_blk edge detector SHALL be re-armed in DEC_START, so a stale high level is never treated as completion.
REQ-029 DONE SHALL last one cycle, with frame_done=1 and both busy signals low; it SHALL update last_served, and the FSM SHALL then return to IDLE.
REQ-030 Requests SHALL be ignored outside IDLE; a request still high after DONE SHALL be re-arbitrated in IDLE.
REQ-031 blk_cnt SHALL hold its value outside CMP_RUN and SHALL saturate at 2047.

Reset
REQ-032 When reset=1 at an edge, the FSM SHALL go to IDLE, last_served to DEC, and blk_cnt and the watchdog to 0.
REQ-033 When reset=1 at an edge, every output SHALL be 0, including while a frame is in progress; no start pulse or frame_done SHALL be emitted on abort.

Configuration
REQ-034 Macro RM_SCHED_TIMEOUT_EN defined: the watchdog counter SHALL run in CMP_ARM, CMP_RUN and DEC_RUN.
REQ-035 The watchdog counter SHALL clear on state entry, yc_sof and cmp_blk_done.
REQ-036 When the watchdog counter reaches TIMEOUT_CYC-1, err_timeout SHALL set and the FSM SHALL go to IDLE with no frame_done.
REQ-037 err_timeout SHALL clear only on err_clr or reset; err_clr and a simultaneous timeout SHALL leave it set.
REQ-038 Macro RM_SCHED_TIMEOUT_EN undefined: no counter SHALL be present, err_timeout SHALL be tied 0, err_clr SHALL be unused, and the FSM SHALL wait indefinitely.

Verification
REQ-039 Scenario: CMP_BLKS=4, cmp_req=1, yc_sof at cycle 10, then 4 cmp_blk_done pulses -> compress_start once, blk_cnt 0..4, frame_done one cycle after the 4th pulse, compress_on low in DONE.
REQ-040 Scenario: dec_req=1, last_dec_blk held high from before the start, rising again 50 cycles after decompress_start -> one decompress_start pulse, frame_done one cycle after the edge.
REQ-041 Scenario: cmp_req=dec_req=1 from reset for 3 frames -> grant order compress, decompress, compress.
REQ-042 Scenario: cmp_req dropped in CMP_ARM before yc_sof -> IDLE, no compress_start, no frame_done.
REQ-043 Scenario: reset pulsed mid CMP_RUN with blk_cnt=2 -> next cycle all outputs 0, FSM in IDLE.
REQ-044 Scenario: RM_SCHED_TIMEOUT_EN defined, TIMEOUT_CYC=64, dec_req with no last_dec_blk -> err_timeout high 64 cycles after DEC_RUN entry, FSM in IDLE; err_clr clears it.

Source files
------------

// File: rtl/rm_frame_sched.sv
// rm_frame_sched: compress/decompress frame scheduler for the rate-match buffer.
// Defining RM_SCHED_TIMEOUT_EN adds a watchdog that aborts stalled frames and raises err_timeout.
module rm_frame_sched #(
    parameter int CMP_BLKS    = 900,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmp_req,
    input  logic        dec_req,
    input  logic        yc_sof,
    input  logic        cmp_blk_done,
    input  logic        last_dec_blk,
    input  logic        err_clr,
    output logic        compress_on,
    output logic        compress_start,
    output logic        decompress_start,
    output logic        cmp_busy,
    output logic        dec_busy,
    output logic        frame_done,
    output logic [10:0] blk_cnt,
    output logic        err_timeout
);
    typedef enum logic [2:0] {IDLE, CMP_ARM, CMP_RUN, DEC_START, DEC_RUN, DONE} state_t;
    state_t r_state, w_nxt;
    logic r_last_cmp, r_is_cmp, r_ldb_prev, r_cmp_on, r_dec_busy, r_cstart, r_dstart, r_done;
    logic [10:0] r_blk;
    logic w_grant_cmp, w_to;

    // Compress wins unless it was the type served last and decompress is also waiting
    assign w_grant_cmp = cmp_req & (~dec_req | ~r_last_cmp);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:      w_nxt = w_grant_cmp ? CMP_ARM : dec_req ? DEC_START : IDLE;
            CMP_ARM:   w_nxt = !cmp_req ? IDLE : yc_sof ? CMP_RUN : CMP_ARM;
            CMP_RUN:   w_nxt = (cmp_blk_done && r_blk == 11'(CMP_BLKS - 1)) ? DONE : CMP_RUN;
            DEC_START: w_nxt = DEC_RUN;
            DEC_RUN:   w_nxt = (last_dec_blk && !r_ldb_prev) ? DONE : DEC_RUN;
            default:   w_nxt = IDLE;
        endcase
        if (w_to) w_nxt = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last_cmp <= 1'b0;
            r_is_cmp   <= 1'b0;
            r_ldb_prev <= 1'b0;
            r_blk      <= '0;
            r_cmp_on   <= 1'b0;
            r_dec_busy <= 1'b0;
            r_cstart   <= 1'b0;
            r_dstart   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_ldb_prev <= last_dec_blk;
            r_cmp_on   <= w_nxt == CMP_ARM || w_nxt == CMP_RUN;
            r_dec_busy <= w_nxt == DEC_START || w_nxt == DEC_RUN;
            r_cstart   <= r_state == CMP_ARM && w_nxt == CMP_RUN;
            r_dstart   <= w_nxt == DEC_START;
            r_done     <= w_nxt == DONE;
            if (r_state == IDLE) r_is_cmp <= w_grant_cmp;
            if (r_state == DONE) r_last_cmp <= r_is_cmp;
            if (r_state == CMP_ARM && w_nxt == CMP_RUN) r_blk <= '0;
            else if (r_state == CMP_RUN && cmp_blk_done && r_blk != '1) r_blk <= r_blk + 11'd1;
        end
    end

`ifdef RM_SCHED_TIMEOUT_EN
    localparam int WD = $clog2(TIMEOUT_CYC + 1);
    logic [WD-1:0] r_wdog;
    logic r_err, w_wd_st;
    assign w_wd_st = r_state == CMP_ARM || r_state == CMP_RUN || r_state == DEC_RUN;
    assign w_to = w_wd_st && r_wdog == WD'(TIMEOUT_CYC - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= (w_wd_st && w_nxt == r_state && !yc_sof && !cmp_blk_done) ? r_wdog + 1'b1 : '0;
            r_err  <= w_to | (r_err & ~err_clr);
        end
    end
    assign err_timeout = r_err;
`else
    logic w_unused;
    assign w_unused    = err_clr | (TIMEOUT_CYC == 0);
    assign w_to        = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign compress_on      = r_cmp_on;
    assign cmp_busy         = r_cmp_on;
    assign dec_busy         = r_dec_busy;
    assign compress_start   = r_cstart;
    assign decompress_start = r_dstart;
    assign frame_done       = r_done;
    assign blk_cnt          = r_blk;
endmodule
